// File: rtl/scan_decoder_if.sv
// Bus between a controller and scan_decoder: decode select handshake,
// scan control, and the registered decode/scan outputs.
interface scan_decoder_if #(
  parameter int SEL_W = 3,
  parameter int PER_W = 8
);
  localparam int OUT_W = 2**SEL_W;

  logic             en;
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             sel_ready;
  logic             start;
  logic             abort;
  logic [PER_W-1:0] period;
  logic [OUT_W-1:0] d;
  logic             d_valid;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, sel, sel_valid, start, abort, period,
    input  sel_ready, d, d_valid, busy, done
  );

  modport slave (
    input  en, mode, sel, sel_valid, start, abort, period,
    output sel_ready, d, d_valid, busy, done
  );
endinterface

// File: rtl/scan_decoder.sv
// One-hot / thermometer decoder with a timed walking-one scan mode.
// All outputs except sel_ready are registered.
//
// state  | meaning
// IDLE   | accepts sel decodes; mode 10 + start launches a scan
// SCAN   | walking one across d, each step held period+1 enabled cycles
// FINISH | one-cycle done pulse, d cleared, then back to IDLE
module scan_decoder #(
  parameter int SEL_W = 3,
  parameter int PER_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  scan_decoder_if.slave bus
);
  localparam int OUT_W = 2**SEL_W;

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  state_t           state, state_n;
  logic [OUT_W-1:0] d_q, d_n;
  logic             dv_q, dv_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic [PER_W-1:0] cnt, cnt_n;
  logic [PER_W-1:0] per_l, per_n;
  logic [SEL_W-1:0] step, step_n;
  logic [OUT_W-1:0] therm, onehot;
  logic             sel_ready;

  assign sel_ready     = (state == IDLE) && (bus.mode != 2'b10);
  assign bus.sel_ready = sel_ready;
  assign bus.d         = d_q;
  assign bus.d_valid   = dv_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_comb begin
    therm  = '0;
    onehot = '0;
    for (int i = 0; i < OUT_W; i++) therm[i] = (SEL_W'(i) <= bus.sel);
    onehot[bus.sel] = 1'b1;
  end

  always_comb begin
    state_n = state;
    d_n     = d_q;
    dv_n    = 1'b0;
    busy_n  = busy_q;
    done_n  = 1'b0;
    cnt_n   = cnt;
    per_n   = per_l;
    step_n  = step;
    if (bus.en) begin
      unique case (state)
        IDLE: begin
          if (bus.mode == 2'b10 && bus.start) begin
            state_n = SCAN;
            per_n   = bus.period;
            busy_n  = 1'b1;
            step_n  = '0;
            cnt_n   = '0;
            d_n     = OUT_W'(1);
          end else if (bus.sel_valid && sel_ready) begin
            d_n  = (bus.mode == 2'b01) ? therm : onehot;
            dv_n = 1'b1;
          end
        end
        SCAN: begin
          // abort wins over a coincident dwell expiry
          if (bus.abort) begin
            state_n = IDLE;
            d_n     = '0;
            busy_n  = 1'b0;
            cnt_n   = '0;
            step_n  = '0;
          end else if (cnt == per_l) begin
            cnt_n = '0;
            if (step == SEL_W'(OUT_W - 1)) begin
              state_n = FINISH;
              d_n     = '0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              step_n  = '0;
            end else begin
              step_n = step + SEL_W'(1);
              d_n    = d_q << 1;
            end
          end else begin
            cnt_n = cnt + PER_W'(1);
          end
        end
        FINISH: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      d_q    <= '0;
      dv_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
      per_l  <= '0;
      step   <= '0;
    end else begin
      state  <= state_n;
      d_q    <= d_n;
      dv_q   <= dv_n;
      busy_q <= busy_n;
      done_q <= done_n;
      cnt    <= cnt_n;
      per_l  <= per_n;
      step   <= step_n;
    end
  end
endmodule
